dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
Shares the single-port 32-bit data memory between two requesters. Port 0 is the core load/store unit; port 1 is the debug/DMA port. Uses round-robin arbitration with valid/ready request and response channels, and allows one outstanding access at a time. Drives the memory's we/addr/wdata and captures its asynchronous rdata into a registered response.

Parameters:
DEPTH, 64, number of 32-bit words in the attached memory; word index = addr[31:2]
AW, 32, request address width in bits

Ports:
clk  in  1  single clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
p0_req_valid  in  1  port 0 request valid
p0_req_ready  out  1  port 0 request accepted this cycle when valid&ready
p0_req_we  in  1  1=write, 0=read
p0_req_addr  in  AW  byte address
p0_req_wdata  in  32  write data
p0_rsp_valid  out  1  port 0 response valid
p0_rsp_ready  in  1  port 0 response consumed when valid&ready
p0_rsp_rdata  out  32  read data; 0 for writes and errors
p0_rsp_err  out  1  address out of range (or misaligned, see feature)
p1_*  same set as p0_*, for port 1
mem_we  out  1  memory write enable
mem_addr  out  AW  memory byte address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory asynchronous read data

Behaviour:
- FSM states: IDLE, RESP. Reset (reset_n low, async) -> IDLE, rr_ptr=0, both rsp_valid=0, rsp_rdata=0, rsp_err=0, owner=0.
- IDLE: winner = the only valid port; if both valid, winner = rr_ptr. Drive winner's req_ready=1 combinationally; loser's req_ready=0. If neither is valid, both req_ready=0 (no speculative ready).
- Accept cycle (winner valid&ready): mem_addr=winner addr, mem_wdata=winner wdata, mem_we = winner we AND in_range. in_range = addr[31:2] < DEPTH.
- Also in the accept cycle, register: rdata = (read & in_range) ? mem_rdata : 0; err = !in_range; owner=winner; rr_ptr = ~winner. Next state RESP.
- Outside accept cycles: mem_we=0, and mem_addr/mem_wdata=0.
- RESP: owner's rsp_valid=1, with rdata/err held stable until owner rsp_ready=1. Then go to IDLE next cycle. Both req_ready=0 throughout RESP.
- Latency: request accepted in cycle N; rsp_valid first high in cycle N+1; earliest next accept is cycle N+2. Maximum throughput is one access per 2 cycles.
- Writes always produce a response (rdata=0), so the requester knows the write has committed.
- An out-of-range access performs no memory write and returns err=1, rdata=0.
- The other port's request may stay valid during RESP. It wins the next IDLE cycle if rr_ptr points to it or it is the only requester. Starvation bound: one access.
- Reset mid-operation (in RESP): the response is dropped and rsp_valid clears immediately (async). No pending memory write exists after the accept cycle.
- A requester deasserting valid before acceptance is legal. The block must not issue a memory access for it.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: an access with addr[1:0] != 0 is treated like out-of-range: no write, err=1, rdata=0.
- Undefined: addr[1:0] is ignored and the access uses word index addr[31:2].

Test Plan:
- Port 0 writes 0xDEADBEEF at addr 0x10, then reads 0x10 -> write resp err=0, rdata=0; read resp rdata=0xDEADBEEF one cycle after accept; mem_we high exactly one cycle.
- Both ports valid every cycle, reading from reset -> grants alternate 0,1,0,1 starting with port 0; each accept is 2 cycles apart.
- Port 1 write to addr 0x100 (word 64, DEPTH=64) -> mem_we stays 0, p1_rsp_err=1, p1_rsp_rdata=0; a following read of word 0 is unchanged.
- p0_rsp_ready held low 5 cycles with p1 valid -> p0_rsp_valid held with stable data; p1_req_ready stays 0 until the cycle after p0 consumes the response.
- reset_n pulsed low while in RESP -> rsp_valid drops in the same cycle; after release, rr_ptr=0 and a simultaneous request grants port 0.
- Read of addr 0x13 -> with MISALIGN_CHECK_EN, err=1 and rdata=0; without it, returns word 4 data with err=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 32-bit data memory.
// Optional build macro MISALIGN_CHECK_EN turns unaligned addresses into error responses.
module dmem_port_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_we,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [31:0]   p0_req_wdata,
  output logic          p0_rsp_valid,
  input  logic          p0_rsp_ready,
  output logic [31:0]   p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_we,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [31:0]   p1_req_wdata,
  output logic          p1_rsp_valid,
  input  logic          p1_rsp_ready,
  output logic [31:0]   p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  localparam logic [AW-3:0] WORD_DEPTH = (AW-2)'(DEPTH);

  state_t        state_reg, state_next;
  logic          rr_ptr_reg, rr_ptr_next;
  logic          owner_reg, owner_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          err_reg, err_next;

  logic          winner;
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          in_range;
  logic          aligned;
  logic          access_ok;

  // A lone requester wins outright; a tie goes to the round-robin pointer.
  assign winner    = (p0_req_valid && p1_req_valid) ? rr_ptr_reg : p1_req_valid;
  assign accept    = (state_reg == IDLE) && (p0_req_valid || p1_req_valid);
  assign sel_we    = winner ? p1_req_we    : p0_req_we;
  assign sel_addr  = winner ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = winner ? p1_req_wdata : p0_req_wdata;
  assign in_range  = sel_addr[AW-1:2] < WORD_DEPTH;

`ifdef MISALIGN_CHECK_EN
  assign aligned = (sel_addr[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

  assign access_ok = in_range && aligned;

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    owner_next   = owner_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          p0_req_ready = !winner;
          p1_req_ready = winner;
          mem_we       = sel_we && access_ok;
          mem_addr     = sel_addr;
          mem_wdata    = sel_wdata;
          // Asynchronous memory read data is captured in the same cycle as the request.
          rdata_next   = (!sel_we && access_ok) ? mem_rdata : 32'd0;
          err_next     = !access_ok;
          owner_next   = winner;
          rr_ptr_next  = !winner;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (owner_reg ? p1_rsp_ready : p0_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 1'b0;
      owner_reg  <= 1'b0;
      rdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
    end
  end

  // Response valid derives from the state register, so an async reset drops it immediately.
  assign p0_rsp_valid = (state_reg == RESP) && !owner_reg;
  assign p1_rsp_valid = (state_reg == RESP) && owner_reg;
  assign p0_rsp_rdata = owner_reg ? 32'd0 : rdata_reg;
  assign p1_rsp_rdata = owner_reg ? rdata_reg : 32'd0;
  assign p0_rsp_err   = !owner_reg && err_reg;
  assign p1_rsp_err   = owner_reg && err_reg;

endmodule
